seq_pattern_detector: RTL and testbench

Parametrised Moore-type serial pattern detector: successor to the team's fixed six-state sequence detector. Watches a one-bit serial stream, compares it against a runtime-loadable pattern of 1..MAX_LEN bits and raises a registered one-cycle Moore output per match. Selectable overlapping or non-overlapping detection and a saturating match counter. Sits on the serial-input path in front of the control logic that consumes match events.

---
 rtl/seq_pattern_detector.sv | 114 +++++++++++
 tb/tb_seq_pattern_detector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Moore serial pattern detector: runtime-loadable 1..MAX_LEN-bit pattern,
// optional overlapping detection and a saturating match counter.
module seq_pattern_detector #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               in_valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LW-1:0]      pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    BAD  = 2'b11
  } state_e;

  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) return LW'(1);
    if (l > MAX_L) return MAX_L;
    return l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e             state_q;
  logic [MAX_LEN-1:0] pr_q;
  logic [LW-1:0]      lr_q;
  // The oldest history bit is only ever needed inside the compare window,
  // so one bit fewer is stored than the window is wide.
  logic [MAX_LEN-2:0] hist_q;
  logic [LW-1:0]      fc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LW-1:0]      fc_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               match_d;
  logic               accept;

  always_comb begin
    hist_d = {hist_q, x};
    fc_d   = (fc_q == MAX_L) ? fc_q : fc_q + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < lr_q);
    end
    match_d = (fc_d >= lr_q) && (((hist_d ^ pr_q) & len_mask) == '0);
    accept  = in_valid && !load && ((state_q == RUN) || (state_q == HIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pr_q    <= '0;
      lr_q    <= LW'(1);
      hist_q  <= '0;
      fc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (load) begin
        pr_q    <= pat;
        lr_q    <= clamp_len(pat_len);
        hist_q  <= '0;
        fc_q    <= '0;
        state_q <= RUN;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          RUN, HIT: begin
            if (in_valid) begin
              hist_q <= hist_d[MAX_LEN-2:0];
              if (match_d) begin
                state_q <= HIT;
                fc_q    <= overlap ? fc_d : '0;
              end else begin
                state_q <= RUN;
                fc_q    <= fc_d;
              end
            end else begin
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // clear and load both override a coincident increment
      if (load || clear) begin
        cnt_q <= '0;
      end else if (accept && match_d) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign y           = (state_q == HIT);
  assign state       = state_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: vector table plus hand-written corner
// sequences, checked through an expected-result queue.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_H = 2'b10;

  logic               clk = 1'b0;
  logic               rst;
  logic               x;
  logic               in_valid;
  logic               load;
  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      pat_len;
  logic               overlap;
  logic               clear;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state;

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .load(load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .clear(clear),
    .y(y), .match_count(match_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               x;
    logic               v;
    logic               ld;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
    logic               clr;
    logic               ey;
    logic [CNT_W-1:0]   ecnt;
    logic [1:0]         est;
  } vec_t;

  typedef struct {
    int               id;
    logic             ey;
    logic [CNT_W-1:0] ecnt;
    logic [1:0]       est;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  logic [MAX_LEN-1:0] cur_pat;
  logic [LW-1:0]      cur_len;
  logic               cur_ovl;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s vec%0d: got %0h, required %0h", nm, id, act, req);
  endtask

  task automatic add_load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                          input logic o, input logic xb, input logic vb);
    vec_t t;
    cur_pat = p; cur_len = l; cur_ovl = o;
    t = '{x: xb, v: vb, ld: 1'b1, pat: p, len: l, ovl: o, clr: 1'b0,
          ey: 1'b0, ecnt: '0, est: S_R};
    tbl.push_back(t);
  endtask

  task automatic add_bit(input logic xb, input logic vb, input logic cl,
                         input logic ey, input logic [CNT_W-1:0] ec, input logic [1:0] es);
    vec_t t;
    t = '{x: xb, v: vb, ld: 1'b0, pat: cur_pat, len: cur_len, ovl: cur_ovl, clr: cl,
          ey: ey, ecnt: ec, est: es};
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int id);
    exp_t e;
    exp_t r;
    x = t.x; in_valid = t.v; load = t.ld; pat = t.pat;
    pat_len = t.len; overlap = t.ovl; clear = t.clr;
    e = '{id: id, ey: t.ey, ecnt: t.ecnt, est: t.est};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard vec%0d: got empty queue, required one entry", id);
    end else begin
      r = exp_q.pop_front();
      chk("y", r.id, 32'(y), 32'(r.ey));
      chk("match_count", r.id, 32'(match_count), 32'(r.ecnt));
      chk("state", r.id, 32'(state), 32'(r.est));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t h;
    x = 0; in_valid = 0; load = 0; pat = '0; pat_len = '0; overlap = 0; clear = 0;
    cur_pat = '0; cur_len = '0; cur_ovl = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_y", 0, 32'(y), 32'd0);
    chk("reset_count", 0, 32'(match_count), 32'd0);
    chk("reset_state", 0, 32'(state), 32'(S_I));
    @(posedge clk);
    #1 rst = 1'b1;

    // IDLE ignores bits until the first load
    repeat (4) add_bit(1, 1, 0, 0, 0, S_I);
    // overlapping 0101
    add_load(8'h05, 4, 1, 0, 0);
    add_bit(0, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 0, 0, S_R);
    add_bit(0, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 1, 1, S_H);
    add_bit(0, 1, 0, 0, 1, S_R); add_bit(1, 1, 0, 1, 2, S_H);
    add_bit(0, 1, 0, 0, 2, S_R);
    // non-overlapping 0101
    add_load(8'h05, 4, 0, 0, 0);
    add_bit(0, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 0, 0, S_R);
    add_bit(0, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 1, 1, S_H);
    add_bit(0, 1, 0, 0, 1, S_R); add_bit(1, 1, 0, 0, 1, S_R);
    add_bit(0, 1, 0, 0, 1, S_R);
    // pattern 11 with gaps in in_valid
    add_load(8'h03, 2, 0, 0, 0);
    add_bit(1, 1, 0, 0, 0, S_R); add_bit(1, 0, 0, 0, 0, S_R);
    add_bit(0, 0, 0, 0, 0, S_R); add_bit(1, 1, 0, 1, 1, S_H);
    add_bit(1, 0, 0, 0, 1, S_R); add_bit(1, 1, 0, 0, 1, S_R);
    add_bit(1, 1, 0, 1, 2, S_H); add_bit(1, 1, 0, 0, 2, S_R);
    add_bit(0, 0, 0, 0, 2, S_R);
    // length 0 clamps to 1; counter saturates; clear beats a match
    add_load(8'h01, 0, 1, 0, 0);
    add_bit(1, 1, 0, 1, 1, S_H); add_bit(1, 1, 0, 1, 2, S_H);
    add_bit(0, 1, 0, 0, 2, S_R); add_bit(1, 1, 0, 1, 3, S_H);
    add_bit(1, 1, 0, 1, 3, S_H); add_bit(1, 1, 0, 1, 3, S_H);
    add_bit(1, 1, 1, 1, 0, S_H); add_bit(0, 1, 0, 0, 0, S_R);
    // length 15 clamps to 8
    add_load(8'hA6, 15, 1, 0, 0);
    add_bit(1, 1, 0, 0, 0, S_R); add_bit(0, 1, 0, 0, 0, S_R);
    add_bit(1, 1, 0, 0, 0, S_R); add_bit(0, 1, 0, 0, 0, S_R);
    add_bit(0, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 0, 0, S_R);
    add_bit(1, 1, 0, 0, 0, S_R); add_bit(0, 1, 0, 1, 1, S_H);
    add_bit(0, 0, 0, 0, 1, S_R);
    // load swallows the bit that would have completed the pattern
    add_load(8'h03, 2, 1, 0, 0);
    add_bit(1, 1, 0, 0, 0, S_R);
    add_load(8'h03, 2, 1, 1, 1);
    add_bit(1, 1, 0, 0, 0, S_R); add_bit(1, 1, 0, 1, 1, S_H);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

    // asynchronous reset mid-stream while y=1 and count=1
    #2 rst = 1'b0;
    #2;
    chk("async_rst_y", 900, 32'(y), 32'd0);
    chk("async_rst_count", 900, 32'(match_count), 32'd0);
    chk("async_rst_state", 900, 32'(state), 32'(S_I));
    @(negedge clk);
    rst = 1'b1;
    h = '{x: 1'b1, v: 1'b1, ld: 1'b0, pat: 8'h01, len: 4'd1, ovl: 1'b1, clr: 1'b0,
          ey: 1'b0, ecnt: '0, est: S_I};
    apply(h, 901);
    apply(h, 902);
    h.ld = 1'b1; h.est = S_R;
    apply(h, 903);
    h.ld = 1'b0; h.ey = 1'b1; h.ecnt = 2'd1; h.est = S_H;
    apply(h, 904);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
